// File: rtl/hatch_loader_mem_pkg.sv
// Shared constants and loader state encoding for the hatch instruction memory
// and its byte-stream program loader.
package hatch_loader_mem_pkg;

  localparam int INSTR_W    = 48;
  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW    = 10;
  localparam int ADDR_W     = 32;
  localparam int WCNT_W     = 11;

  // Index of the final byte of a 6-byte instruction word.
  localparam logic [2:0] LAST_BYTE = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    DONE,
    ERR
  } ld_state_e;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_loading(ld_state_e s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA);
  endfunction

  // A header word count is usable only if it is non-zero and fits the memory.
  function automatic logic count_ok(logic [15:0] n);
    return (n != 16'd0) && (n <= 16'(IMEM_DEPTH));
  endfunction

endpackage

// File: rtl/hatch_loader_mem_if.sv
// Bundle of the fetch port and the program-load stream. The master side is the
// host/CPU environment; the slave side is the loader memory.
interface hatch_loader_mem_if;
  import hatch_loader_mem_pkg::*;

  logic [ADDR_W-1:0]  hatch_address;
  logic [INSTR_W-1:0] hatch_instruction;
  logic               ld_start;
  logic               ld_valid;
  logic [7:0]         ld_data;
  logic               ld_ready;
  logic               ld_busy;
  logic               ld_err;
  logic               cpu_rst_b;
  logic [WCNT_W-1:0]  words_loaded;

  modport master (
    output hatch_address, ld_start, ld_valid, ld_data,
    input  hatch_instruction, ld_ready, ld_busy, ld_err, cpu_rst_b, words_loaded
  );

  modport slave (
    input  hatch_address, ld_start, ld_valid, ld_data,
    output hatch_instruction, ld_ready, ld_busy, ld_err, cpu_rst_b, words_loaded
  );

endinterface

// File: rtl/hatch_imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded program survives a reset.
module hatch_imem_ram
  import hatch_loader_mem_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IMEM_AW-1:0] waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [IMEM_AW-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_reg [IMEM_DEPTH];

  // Write port: a word lands on the clock edge and is readable right after.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Zero-latency fetch path.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/hatch_loader_mem.sv
// Instruction memory with a byte-stream program loader. A frame is a 16-bit
// big-endian word count followed by that many 6-byte big-endian words. The CPU
// is held in reset until a frame completes successfully.
module hatch_loader_mem
  import hatch_loader_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  hatch_loader_mem_if.slave bus
);

  ld_state_e         state_reg, state_next;
  logic [15:0]       count_reg, count_next;
  logic [2:0]        byte_cnt_reg, byte_cnt_next;
  logic [39:0]       shift_reg, shift_next;
  logic [WCNT_W-1:0] words_loaded_reg, words_loaded_next;

  logic ld_ready_reg;
  logic ld_busy_reg;
  logic ld_err_reg;
  logic cpu_rst_b_reg;

  logic               accept;
  logic               word_done;
  logic [INSTR_W-1:0] ram_rdata;
  logic [15:0]        hdr_count;
  logic [15:0]        words_after_write;

  // ld_start always wins over a byte presented in the same cycle.
  assign accept    = bus.ld_valid && ld_ready_reg && !bus.ld_start;
  assign word_done = accept && (state_reg == DATA) && (byte_cnt_reg == LAST_BYTE);

  assign hdr_count         = {count_reg[15:8], bus.ld_data};
  assign words_after_write = 16'(words_loaded_reg) + 16'd1;

  hatch_imem_ram u_ram (
    .clk   (clk),
    .we    (word_done),
    .waddr (words_loaded_reg[IMEM_AW-1:0]),
    .wdata ({shift_reg, bus.ld_data}),
    .raddr (bus.hatch_address[IMEM_AW-1:0]),
    .rdata (ram_rdata)
  );

  // Next-state and datapath decode for the loader.
  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    byte_cnt_next     = byte_cnt_reg;
    shift_next        = shift_reg;
    words_loaded_next = words_loaded_reg;

    if (bus.ld_start) begin
      // Restart from any state; a partial word in flight is simply dropped.
      state_next        = HDR_HI;
      count_next        = 16'd0;
      byte_cnt_next     = 3'd0;
      words_loaded_next = '0;
    end else if (accept) begin
      unique case (state_reg)
        HDR_HI: begin
          count_next[15:8] = bus.ld_data;
          state_next       = HDR_LO;
        end
        HDR_LO: begin
          count_next = hdr_count;
          state_next = count_ok(hdr_count) ? DATA : ERR;
        end
        DATA: begin
          if (byte_cnt_reg == LAST_BYTE) begin
            byte_cnt_next     = 3'd0;
            words_loaded_next = words_loaded_reg + 1'b1;
            if (words_after_write == count_reg) begin
              state_next = DONE;
            end
          end else begin
            byte_cnt_next = byte_cnt_reg + 3'd1;
            shift_next    = {shift_reg[31:0], bus.ld_data};
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      count_reg        <= 16'd0;
      byte_cnt_reg     <= 3'd0;
      shift_reg        <= 40'd0;
      words_loaded_reg <= '0;
      ld_ready_reg     <= 1'b0;
      ld_busy_reg      <= 1'b0;
      ld_err_reg       <= 1'b0;
      cpu_rst_b_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      byte_cnt_reg     <= byte_cnt_next;
      shift_reg        <= shift_next;
      words_loaded_reg <= words_loaded_next;
      ld_ready_reg     <= is_loading(state_next);
      ld_busy_reg      <= is_loading(state_next);
      ld_err_reg       <= (state_next == ERR);
      cpu_rst_b_reg    <= (state_next == DONE);
    end
  end

  // Addresses beyond the memory read as zero.
  assign bus.hatch_instruction = (bus.hatch_address[ADDR_W-1:IMEM_AW] != '0) ? '0 : ram_rdata;

  assign bus.ld_ready     = ld_ready_reg;
  assign bus.ld_busy      = ld_busy_reg;
  assign bus.ld_err       = ld_err_reg;
  assign bus.cpu_rst_b    = cpu_rst_b_reg;
  assign bus.words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_hatch_loader_mem.sv
// Directed bench for the hatch loader memory: reset state, a two-word load,
// header errors, abort and restart, throttled valid, full-depth load,
// out-of-range fetch and reset in the middle of a load.
module tb_hatch_loader_mem;
  import hatch_loader_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hatch_loader_mem_if bus ();

  hatch_loader_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.ld_start = 1'b1;
    @(posedge clk);
    #1;
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ld_ready) check_eq("ready_timeout", 64'(bus.ld_ready), 64'd1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [47:0] w);
    for (int k = 0; k < 6; k++) send_byte(w[47-8*k -: 8]);
  endtask

  // Idle cycle with garbage data, then one valid cycle.
  task automatic send_toggled(input logic [7:0] b);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'hEE;
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 8'hEE;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] addr, input logic [47:0] exp);
    bus.hatch_address = addr;
    #1;
    check_eq(tag, 64'(bus.hatch_instruction), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    bus.hatch_address = 32'd0;
    bus.ld_start      = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.ld_data       = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cpu_rst_b", 64'(bus.cpu_rst_b), 64'd0);
    check_eq("rst_ready", 64'(bus.ld_ready), 64'd0);
    check_eq("rst_busy", 64'(bus.ld_busy), 64'd0);
    check_eq("rst_err", 64'(bus.ld_err), 64'd0);
    check_eq("rst_words", 64'(bus.words_loaded), 64'd0);
    $display("reset state checked");

    // Two-word load.
    pulse_start();
    check_eq("a_busy", 64'(bus.ld_busy), 64'd1);
    check_eq("a_ready", 64'(bus.ld_ready), 64'd1);
    check_eq("a_cpu_held", 64'(bus.cpu_rst_b), 64'd0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(48'h112233445566);
    check_eq("a_words1", 64'(bus.words_loaded), 64'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hDD); send_byte(8'hEE);
    check_eq("a_cpu_before_last", 64'(bus.cpu_rst_b), 64'd0);
    send_byte(8'hFF);
    check_eq("a_cpu_after_last", 64'(bus.cpu_rst_b), 64'd1);
    check_eq("a_words2", 64'(bus.words_loaded), 64'd2);
    check_eq("a_ready_done", 64'(bus.ld_ready), 64'd0);
    check_eq("a_busy_done", 64'(bus.ld_busy), 64'd0);
    check_mem("a_word0", 32'd0, 48'h112233445566);
    check_mem("a_word1", 32'd1, 48'hAABBCCDDEEFF);
    // DONE must ignore a presented byte.
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h55;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    check_eq("a_done_ignores_words", 64'(bus.words_loaded), 64'd2);
    check_mem("a_done_ignores_word2", 32'd2 - 32'd2, 48'h112233445566);
    $display("two-word load checked");

    // Header count too large.
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h01);
    check_eq("e_err", 64'(bus.ld_err), 64'd1);
    check_eq("e_ready", 64'(bus.ld_ready), 64'd0);
    check_eq("e_cpu", 64'(bus.cpu_rst_b), 64'd0);
    check_eq("e_busy", 64'(bus.ld_busy), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("e_err_sticky", 64'(bus.ld_err), 64'd1);
    pulse_start();
    check_eq("e_err_cleared", 64'(bus.ld_err), 64'd0);
    // Zero count is also an error.
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("e_zero_err", 64'(bus.ld_err), 64'd1);
    $display("header error checked");

    // Abort after three bytes of word 1, restart with ld_valid held high.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(48'h010203040506);
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h09);
    check_eq("b_words_before_abort", 64'(bus.words_loaded), 64'd1);
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h00;
    @(posedge clk);
    #1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    check_eq("b_words_cleared", 64'(bus.words_loaded), 64'd0);
    check_eq("b_busy", 64'(bus.ld_busy), 64'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(48'h0000000000AB);
    check_eq("b_err", 64'(bus.ld_err), 64'd0);
    check_eq("b_words", 64'(bus.words_loaded), 64'd1);
    check_eq("b_cpu", 64'(bus.cpu_rst_b), 64'd1);
    check_mem("b_word0", 32'd0, 48'h0000000000AB);
    check_mem("b_word1_kept", 32'd1, 48'hAABBCCDDEEFF);
    $display("abort and restart checked");

    // One-word load with ld_valid toggling every other cycle.
    pulse_start();
    send_toggled(8'h00);
    send_toggled(8'h01);
    send_toggled(8'h5A); send_toggled(8'h5A); send_toggled(8'h00);
    send_toggled(8'hC3); send_toggled(8'h0F); send_toggled(8'h71);
    check_eq("t_words", 64'(bus.words_loaded), 64'd1);
    check_eq("t_cpu", 64'(bus.cpu_rst_b), 64'd1);
    check_mem("t_word0", 32'd0, 48'h5A5A00C30F71);
    $display("toggled valid load checked");

    // Full-depth load of 1024 words.
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 1024; i++) begin
      send_word({8'hA5, 30'd0, i[9:0]});
    end
    check_eq("f_words", 64'(bus.words_loaded), 64'd1024);
    check_eq("f_cpu", 64'(bus.cpu_rst_b), 64'd1);
    check_eq("f_err", 64'(bus.ld_err), 64'd0);
    check_mem("f_word3ff", 32'h000003FF, {8'hA5, 30'd0, 10'h3FF});
    check_mem("f_addr400", 32'h00000400, 48'h0);
    check_mem("f_addr_high", 32'h80000005, 48'h0);
    check_mem("f_word0", 32'd0, {8'hA5, 30'd0, 10'h000});
    check_mem("f_word5", 32'd5, {8'hA5, 30'd0, 10'h005});
    $display("full-depth load checked");

    // Reset on the cycle the final byte of a word is presented.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55);
    @(negedge clk);
    rst          = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h66;
    #1;
    check_eq("r_busy_async", 64'(bus.ld_busy), 64'd0);
    check_eq("r_ready_async", 64'(bus.ld_ready), 64'd0);
    check_eq("r_words_async", 64'(bus.words_loaded), 64'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.ld_valid = 1'b0;
    check_mem("r_word0_kept", 32'd0, {8'hA5, 30'd0, 10'h000});
    @(negedge clk);
    check_eq("r_cpu_held", 64'(bus.cpu_rst_b), 64'd0);
    check_eq("r_idle_ready", 64'(bus.ld_ready), 64'd0);
    $display("reset mid-load checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hatch_loader_mem.md
HATCH_LOADER_MEM -- requirements
Module: hatch_loader_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port hatch_address, input, 32 bits: word-indexed instruction address from the CPU fetch stage.
REQ-005 Port hatch_instruction, output, 48 bits: instruction word for hatch_address.
REQ-006 Port ld_start, input, 1 bit: single-cycle pulse that begins (or restarts) a program load.
REQ-007 Port ld_valid, input, 1 bit: ld_data holds a byte.
REQ-008 Port ld_data, input, 8 bits: program byte stream.
REQ-009 Port ld_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 Port ld_busy, output, 1 bit: a load is in progress.
REQ-011 Port ld_err, output, 1 bit: the last load header was invalid.
REQ-012 Port cpu_rst_b, output, 1 bit: active-low reset driven to the CPU.
REQ-013 Port words_loaded, output, 11 bits: count of words written by the current or most recent load.

Function
REQ-014 Storage SHALL be 1024 x 48-bit words, indexed by hatch_address[9:0].
REQ-015 Reads SHALL be asynchronous: hatch_instruction reflects hatch_address in the same cycle, with zero latency.
REQ-016 hatch_instruction SHALL be 48'h0 whenever hatch_address[31:10] != 0.
REQ-017 The load frame SHALL consist of a 16-bit big-endian word count N, followed by N words of 6 bytes each, big-endian (first byte = bits 47:40).
REQ-018 The state machine SHALL have the states IDLE, HDR_HI, HDR_LO, DATA, DONE and ERR.
REQ-019 ld_start in any state SHALL move the machine to HDR_HI, clear words_loaded, clear ld_err and drive cpu_rst_b=0 on the next cycle.
REQ-020 If ld_start and ld_valid are high in the same cycle, ld_start SHALL win and the byte SHALL NOT be consumed.
REQ-021 A byte SHALL be accepted only when ld_valid && ld_ready && !ld_start.
REQ-022 ld_ready SHALL be 1 in HDR_HI, HDR_LO and DATA, and 0 otherwise; it is a function of registered state only.
REQ-023 HDR_HI SHALL latch the count high byte on acceptance, then go to HDR_LO.
REQ-024 HDR_LO SHALL latch the count low byte on acceptance; if N is 0 or N > 1024 it SHALL go to ERR, otherwise to DATA.
REQ-025 DATA SHALL assemble bytes in a 3-bit byte counter (0..5) and a 40-bit shift register.
REQ-026 On acceptance of byte 5, DATA SHALL write the word to address words_loaded[9:0] and increment words_loaded.
REQ-027 A written word SHALL be visible on hatch_instruction from the following cycle.
REQ-028 When words_loaded reaches N, the machine SHALL enter DONE on the same edge as the final write.
REQ-029 cpu_rst_b SHALL be 1 only in DONE; it rises on the cycle after the final write.
REQ-030 In ERR, ld_err SHALL be 1 and cpu_rst_b SHALL be 0; the machine stays in ERR until ld_start.
REQ-031 ld_busy SHALL be 1 in HDR_HI, HDR_LO and DATA.
REQ-032 IDLE and DONE SHALL ignore ld_valid.
REQ-033 An aborted load (ld_start during DATA) SHALL leave previously written words intact and discard any partial word.

Reset
REQ-034 On rst the block SHALL enter IDLE with cpu_rst_b=0, ld_ready=0, ld_busy=0, ld_err=0, words_loaded=0, byte counter 0 and count register 0.
REQ-035 Memory contents SHALL NOT be reset; the CPU stays held in reset until a successful load.
REQ-036 rst asserted mid-load SHALL abort immediately, with no further writes.

Structure
REQ-037 Constants INSTR_W=48, IMEM_DEPTH=1024 and IMEM_AW=10, plus the loader state enum, SHALL live in the shared cpu package.
REQ-038 One sub-module, hatch_imem_ram, SHALL hold the array: one synchronous write port and one asynchronous read port.

Verification
REQ-039 Reset, then probe hatch_address=0 -> cpu_rst_b=0, ld_ready=0, ld_busy=0, ld_err=0, words_loaded=0.
REQ-040 Pulse ld_start, then send bytes 00 02 | 11 22 33 44 55 66 | AA BB CC DD EE FF -> word 0 = 48'h112233445566 and word 1 = 48'hAABBCCDDEEFF; cpu_rst_b rises the cycle after the 14th byte; words_loaded=2.
REQ-041 Pulse ld_start, then send header 04 01 -> ld_err=1, ld_ready=0, cpu_rst_b=0; a subsequent ld_start clears ld_err.
REQ-042 Run a 3-word load, pulse ld_start after byte 3 of word 1, then load 1 word 48'h0000000000AB -> word 0 = 48'h0000000000AB, word 1 keeps its old contents, words_loaded=1.
REQ-043 Load 1 word with ld_valid toggled every other cycle -> identical result; bytes are taken only on cycles where ld_valid && ld_ready are both high.
REQ-044 Drive hatch_address=32'h00000400 after a load -> hatch_instruction=48'h0; hatch_address=32'h000003FF -> contents of word 1023.
